// File: rtl/imm_ext_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : imm_ext_pipe_if
//  Description : Handshake bundle for the immediate-extension stage.
//                Input side: in_valid/in_ready with the instruction word and
//                its sideband tag. Output side: out_valid/out_ready with the
//                formatted immediate, format code, illegal flag and tag.
//                master = producer/consumer environment, slave = the stage.
//  Revision    : 1.0  initial release
// ============================================================================
interface imm_ext_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      ins;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ext_out;
    logic [2:0]       ext_kind;
    logic             illegal;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, ins, in_tag, out_ready,
        input  in_ready, out_valid, ext_out, ext_kind, illegal, out_tag
    );

    modport slave (
        input  in_valid, ins, in_tag, out_ready,
        output in_ready, out_valid, ext_out, ext_kind, illegal, out_tag
    );
endinterface
`default_nettype wire

// File: rtl/imm_ext_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : imm_ext_pipe
//  Description : Pipelined immediate-extension stage for the MIPS-31 datapath.
//                Decodes one instruction per handshake into a WIDTH-bit
//                immediate plus a 3-bit format code and an illegal flag, and
//                queues the result in a 2-entry output buffer.
//  Ports       : clk, rst (async, active-high)
//                bus           - imm_ext_pipe_if.slave handshake bundle
//                illegal_count - saturating count of accepted illegal words
//  Revision    : 1.0  initial release
// ============================================================================
module imm_ext_pipe #(
    parameter int WIDTH        = 32,
    parameter int TAG_W        = 5,
    parameter bit LUI_PRESHIFT = 1'b1
) (
    input  wire logic        clk,
    input  wire logic        rst,
    imm_ext_pipe_if.slave    bus,
    output logic [15:0]      illegal_count
);

    localparam logic [2:0] c_KIND_NONE    = 3'd0;
    localparam logic [2:0] c_KIND_SHAMT   = 3'd1;
    localparam logic [2:0] c_KIND_SEXT16  = 3'd2;
    localparam logic [2:0] c_KIND_ZEXT16  = 3'd3;
    localparam logic [2:0] c_KIND_LUI     = 3'd4;
    localparam logic [2:0] c_KIND_BRANCH  = 3'd5;
    localparam logic [2:0] c_KIND_JUMP    = 3'd6;
    localparam logic [2:0] c_KIND_ILLEGAL = 3'd7;

    logic [5:0]       w_opcode;
    logic [5:0]       w_funct;
    logic [2:0]       w_kind;
    logic [WIDTH-1:0] w_ext;
    logic             w_illegal;
    logic             w_push;
    logic             w_pop;

    // Head entry drives the outputs directly; tail holds the second entry.
    logic [1:0]       r_count;
    logic [WIDTH-1:0] r_head_ext;
    logic [2:0]       r_head_kind;
    logic             r_head_ill;
    logic [TAG_W-1:0] r_head_tag;
    logic [WIDTH-1:0] r_tail_ext;
    logic [2:0]       r_tail_kind;
    logic             r_tail_ill;
    logic [TAG_W-1:0] r_tail_tag;
    logic [15:0]      r_illegal_count;

    assign w_opcode = bus.ins[31:26];
    assign w_funct  = bus.ins[5:0];

    always_comb begin
        w_kind = c_KIND_ILLEGAL;
        w_ext  = '0;
        if (w_opcode == 6'b000000) begin
            case (w_funct)
                6'b100000, 6'b100001, 6'b100010, 6'b100011,
                6'b100100, 6'b100101, 6'b100110, 6'b100111,
                6'b101010, 6'b101011, 6'b000100, 6'b000110,
                6'b000111, 6'b001000: begin
                    w_kind = c_KIND_NONE;
                end
                6'b000000, 6'b000010, 6'b000011: begin
                    w_kind = c_KIND_SHAMT;
                    w_ext  = WIDTH'(bus.ins[10:6]);
                end
                default: w_kind = c_KIND_ILLEGAL;
            endcase
        end else begin
            case (w_opcode)
                6'b001000, 6'b001001, 6'b001010,
                6'b001011, 6'b100011, 6'b101011: begin
                    w_kind = c_KIND_SEXT16;
                    w_ext  = {{(WIDTH-16){bus.ins[15]}}, bus.ins[15:0]};
                end
                6'b001100, 6'b001101, 6'b001110: begin
                    w_kind = c_KIND_ZEXT16;
                    w_ext  = WIDTH'(bus.ins[15:0]);
                end
                6'b001111: begin
                    w_kind = c_KIND_LUI;
                    w_ext  = LUI_PRESHIFT ? WIDTH'({bus.ins[15:0], 16'h0000})
                                          : WIDTH'(bus.ins[15:0]);
                end
                6'b000100, 6'b000101: begin
                    w_kind = c_KIND_BRANCH;
                    w_ext  = {{(WIDTH-18){bus.ins[15]}}, bus.ins[15:0], 2'b00};
                end
                6'b000010, 6'b000011: begin
                    w_kind = c_KIND_JUMP;
                    w_ext  = WIDTH'({bus.ins[25:0], 2'b00});
                end
                default: w_kind = c_KIND_ILLEGAL;
            endcase
        end
    end

    assign w_illegal = (w_kind == c_KIND_ILLEGAL);

    // in_ready comes from registered occupancy only; the reset gate keeps the
    // stage closed while rst is held even though count is already zero.
    assign bus.in_ready  = ~rst & ~r_count[1];
    assign bus.out_valid = (r_count != 2'd0);
    assign w_push        = bus.in_valid & bus.in_ready;
    assign w_pop         = bus.out_valid & bus.out_ready;

    assign bus.ext_out   = r_head_ext;
    assign bus.ext_kind  = r_head_kind;
    assign bus.illegal   = r_head_ill;
    assign bus.out_tag   = r_head_tag;
    assign illegal_count = r_illegal_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count         <= 2'd0;
            r_head_ext      <= '0;
            r_head_kind     <= 3'd0;
            r_head_ill      <= 1'b0;
            r_head_tag      <= '0;
            r_tail_ext      <= '0;
            r_tail_kind     <= 3'd0;
            r_tail_ill      <= 1'b0;
            r_tail_tag      <= '0;
            r_illegal_count <= 16'h0000;
        end else begin
            case (r_count)
                2'd0: begin
                    if (w_push) begin
                        r_head_ext  <= w_ext;
                        r_head_kind <= w_kind;
                        r_head_ill  <= w_illegal;
                        r_head_tag  <= bus.in_tag;
                        r_count     <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        // Replace the head in place: no bubble.
                        r_head_ext  <= w_ext;
                        r_head_kind <= w_kind;
                        r_head_ill  <= w_illegal;
                        r_head_tag  <= bus.in_tag;
                    end else if (w_push) begin
                        r_tail_ext  <= w_ext;
                        r_tail_kind <= w_kind;
                        r_tail_ill  <= w_illegal;
                        r_tail_tag  <= bus.in_tag;
                        r_count     <= 2'd2;
                    end else if (w_pop) begin
                        // Head registers keep their last values when empty.
                        r_count     <= 2'd0;
                    end
                end
                2'd2: begin
                    // Full: in_ready is low, so only a pop can happen.
                    if (w_pop) begin
                        r_head_ext  <= r_tail_ext;
                        r_head_kind <= r_tail_kind;
                        r_head_ill  <= r_tail_ill;
                        r_head_tag  <= r_tail_tag;
                        r_count     <= 2'd1;
                    end
                end
                default: r_count <= 2'd0;
            endcase

            if (w_push && w_illegal && (r_illegal_count != 16'hFFFF)) begin
                r_illegal_count <= r_illegal_count + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/imm_ext_pipe.md
# imm_ext_pipe

Pipelined, parametrised immediate-extension stage for the MIPS-31 datapath. It sits between instruction fetch/decode and the ALU/branch/jump operand muxes. It takes one 32-bit instruction per handshake and produces the fully formatted immediate, a format code, an illegal-opcode flag and a passed-through tag. Results go through a 2-entry output buffer with valid/ready flow control, and a saturating counter tracks illegal opcodes.

## Interface
- WIDTH, 32, output datapath width; must be >= 32; all extensions fill to WIDTH.
- TAG_W, 5, width of the sideband tag carried alongside each instruction.
- LUI_PRESHIFT, 1, 1: LUI output is imm16<<16; 0: LUI output is zero-extended imm16.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  an instruction is offered.
- in_ready  out  1  the stage can accept; a transfer occurs when in_valid & in_ready.
- ins  in  32  instruction word.
- in_tag  in  TAG_W  sideband tag, returned unchanged with the result.
- out_valid  out  1  the head buffer entry is valid.
- out_ready  in  1  the consumer accepts; a pop occurs when out_valid & out_ready.
- ext_out  out  WIDTH  extended immediate of the head entry.
- ext_kind  out  3  format code of the head entry.
- illegal  out  1  the head entry had an unrecognised opcode or funct.
- out_tag  out  TAG_W  tag of the head entry.
- illegal_count  out  16  number of illegal instructions accepted; saturates at 0xFFFF.

## Operation
Each accepted instruction is decoded combinationally into one of the following formats. Extensions are sign- or zero-fill to WIDTH.
- ext_kind 0, NONE: opcode 000000 with funct in {100000..100111, 101010, 101011, 000100, 000110, 000111, 001000}; ext_out = 0.
- ext_kind 1, SHAMT: opcode 000000 with funct 000000, 000010 or 000011; zero-extend ins[10:6].
- ext_kind 2, SEXT16: opcodes ADDI 001000, ADDIU 001001, SLTI 001010, SLTIU 001011, LW 100011, SW 101011; sign-extend ins[15:0].
- ext_kind 3, ZEXT16: opcodes ANDI 001100, ORI 001101, XORI 001110; zero-extend ins[15:0].
- ext_kind 4, LUI: opcode 001111; output follows LUI_PRESHIFT.
- ext_kind 5, BRANCH: opcodes BEQ 000100, BNE 000101; sign-extend {ins[15:0], 2'b00} (18 bits).
- ext_kind 6, JUMP: opcodes J 000010, JAL 000011; zero-extend {ins[25:0], 2'b00} (28 bits).
- ext_kind 7, ILLEGAL: any other opcode, or any other funct under opcode 000000; ext_out = 0, illegal = 1. Illegal is 0 for every other kind.
- Output buffer: a 2-entry FIFO {ext_out, ext_kind, illegal, tag} with 2-bit occupancy count (0..2).
  - Push on accept; pop on consume.
  - Push and pop in the same cycle leave count unchanged.
  - Strict FIFO order.
- illegal_count increments by 1 for each accepted ILLEGAL instruction. It holds at 0xFFFF and clears only on reset.

## Timing
- Reset, asynchronous: count = 0, out_valid = 0, ext_out = 0, ext_kind = 0, illegal = 0, out_tag = 0, illegal_count = 0.
- in_ready = 0 while rst is asserted.
- in_ready = (count < 2); it depends only on registered state, with no combinational path from out_ready.
- Latency: an instruction accepted at edge N is presented with out_valid = 1 after edge N, i.e. in cycle N+1.
- Throughput: 1 per cycle sustained when out_ready = 1.
- Full (count = 2): in_ready = 0; ins is ignored; the outputs hold the head entry stable until popped.
- Empty (count = 0): out_valid = 0; ext_out, ext_kind, illegal and out_tag hold their last values.
- Count = 1 with push and pop together: the new entry becomes head on the next cycle; no bubble.
- Output fields stay stable while out_valid = 1 and out_ready = 0.
- Reset asserted mid-operation discards all buffered entries immediately. Nothing is output until a new accept after deassertion.
- Deassertion must meet recovery/removal relative to clk; the first accept can occur at the first edge after deassertion.

## Test plan
- Format sweep, out_ready = 1, WIDTH = 32: expected ext_out one cycle after accept:
  - ADDI 0x2008FFFF -> 0xFFFFFFFF, kind 2.
  - ANDI 0x3008FFFF -> 0x0000FFFF, kind 3.
  - SLL 0x00084080 -> 0x00000002, kind 1.
  - ADD 0x01094020 -> 0x00000000, kind 0.
- Branch, jump and LUI:
  - BEQ 0x1000FFFE -> 0xFFFFFFF8, kind 5.
  - J 0x08000010 -> 0x00000040, kind 6.
  - LUI 0x3C011234 -> 0x12340000 with LUI_PRESHIFT = 1; 0x00001234 with LUI_PRESHIFT = 0.
- WIDTH = 64: LW 0x8C088000 -> 0xFFFFFFFFFFFF8000; J 0x0BFFFFFF -> 0x000000000FFFFFFC.
- Backpressure: hold out_ready = 0 and offer 3 instructions with tags 1, 2, 3.
  - in_ready falls after 2 accepts; tag 3 is held at the input.
  - After raising out_ready, outputs arrive in order 1, 2, 3 with no loss and no duplication.
- Illegal opcode: ins 0xFC000000 -> illegal = 1, ext_out = 0, kind 7, illegal_count 0 -> 1.
  - After preloading the count to 0xFFFF via 65535 illegals, a further illegal leaves it at 0xFFFF.
- Reset mid-operation: with 2 entries buffered, pulse rst between edges.
  - out_valid = 0 and illegal_count = 0 immediately.
  - in_ready = 1 after deassertion; the next accept is output one cycle later.
